// File: rtl/tc_sram_arb2.sv
// Two-requester SRAM arbiter: optional zero-fill after reset, then round-robin or
// fixed-priority arbitration into a registered command stage and response stage.
module tc_sram_arb2 #(
  parameter bit CLEAR_EN = 1'b1,
  parameter bit RR_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  output logic        m0_ready_o,
  input  logic [9:0]  m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_mask_i,
  input  logic        m0_wren_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  output logic        m1_ready_o,
  input  logic [9:0]  m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_mask_i,
  input  logic        m1_wren_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        init_done_o,
  output logic        sram_cs_o,
  output logic        sram_wren_o,
  output logic [9:0]  sram_addr_o,
  output logic [31:0] sram_data_o,
  output logic [3:0]  sram_mask_o,
  input  logic [31:0] sram_data_i
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic        req;   // 0 marks clear-sequence writes, which produce no response
    logic        port;
    logic        wren;
    logic [3:0]  mask;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam logic [9:0] LAST_ADDR = 10'h3FF;

  state_e     state_q, state_d;
  logic [9:0] clr_cnt_q, clr_cnt_d;
  logic       prio_q, prio_d;
  logic       cmd_vld_q, cmd_vld_d;
  cmd_t       cmd_q, cmd_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_port_q, rsp_port_d;
  logic       rsp_wren_q, rsp_wren_d;
  logic       gnt0, gnt1;

  // prio_q names the port that wins the next contended cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_RUN && !rst_i) begin
      if (m0_valid_i && m1_valid_i) begin
        gnt1 = RR_EN && prio_q;
        gnt0 = !gnt1;
      end else begin
        gnt0 = m0_valid_i;
        gnt1 = m1_valid_i;
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    prio_d     = prio_q;
    cmd_vld_d  = 1'b0;
    cmd_d      = cmd_q;
    cmd_d.req  = 1'b0;
    if (state_q == ST_CLEAR) begin
      cmd_vld_d   = 1'b1;
      cmd_d.port  = 1'b0;
      cmd_d.wren  = 1'b1;
      cmd_d.mask  = 4'hF;
      cmd_d.addr  = clr_cnt_q;
      cmd_d.wdata = 32'h0;
      clr_cnt_d   = clr_cnt_q + 10'd1;
      if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end else if (gnt0 || gnt1) begin
      cmd_vld_d   = 1'b1;
      cmd_d.req   = 1'b1;
      cmd_d.port  = gnt1;
      cmd_d.wren  = gnt1 ? m1_wren_i  : m0_wren_i;
      cmd_d.mask  = gnt1 ? m1_mask_i  : m0_mask_i;
      cmd_d.addr  = gnt1 ? m1_addr_i  : m0_addr_i;
      cmd_d.wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
      if (RR_EN) prio_d = gnt0;
    end
    rsp_vld_d  = cmd_vld_q && cmd_q.req;
    rsp_port_d = cmd_q.port;
    rsp_wren_d = cmd_q.wren;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR_EN ? ST_CLEAR : ST_RUN;
      clr_cnt_q  <= '0;
      prio_q     <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      prio_q     <= prio_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_q      <= cmd_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
      rsp_wren_q <= rsp_wren_d;
    end
  end

  // Reset is synchronous, so registers are still stale during the first reset
  // cycle; outputs are forced low for as long as rst_i is high.
  assign m0_ready_o  = gnt0;
  assign m1_ready_o  = gnt1;
  assign init_done_o = (state_q == ST_RUN) && !rst_i;

  assign sram_cs_o   = cmd_vld_q && !rst_i;
  assign sram_wren_o = cmd_q.wren && !rst_i;
  assign sram_addr_o = rst_i ? 10'h0 : cmd_q.addr;
  assign sram_data_o = rst_i ? 32'h0 : cmd_q.wdata;
  assign sram_mask_o = rst_i ? 4'h0  : cmd_q.mask;

  assign m0_rvalid_o = rsp_vld_q && !rsp_port_q && !rst_i;
  assign m1_rvalid_o = rsp_vld_q &&  rsp_port_q && !rst_i;
  assign m0_rdata_o  = (m0_rvalid_o && !rsp_wren_q) ? sram_data_i : 32'h0;
  assign m1_rdata_o  = (m1_rvalid_o && !rsp_wren_q) ? sram_data_i : 32'h0;

endmodule
